// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types and helpers for the parametrised APB4 master (apb_master_mp).
//   apb_state_e : master FSM states (IDLE, SETUP, ACCESS, DECERR)
//   clog2       : ceiling log2, usable in parameter expressions
//   onehot      : 4-bit index to 16-bit one-hot select vector
// No ports.
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DECERR = 2'd3
  } apb_state_e;

  // Widest PSEL vector the master supports.
  localparam int MAX_SLAVES = 16;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 32'sd0;
    rem = value - 32'sd1;
    while (rem > 32'sd0) begin
      res = res + 32'sd1;
      rem = rem >>> 32'sd1;
    end
    return res;
  endfunction

  function automatic logic [MAX_SLAVES-1:0] onehot(input logic [3:0] idx);
    logic [MAX_SLAVES-1:0] one;
    one = 16'h0001;
    return one << idx;
  endfunction

endpackage

// File: rtl/apb_master_mp_if.sv
// -----------------------------------------------------------------------------
// apb_master_mp_if
// Bundles the request/response front-end and the APB4 bus of apb_master_mp.
//   Front-end : req_valid/req_ready/req_write/req_addr/req_wdata/req_strb,
//               rsp_valid/rsp_rdata/rsp_err/rsp_timeout
//   APB4 bus  : PSEL[NUM_SLAVES], PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
//               PRDATA[NUM_SLAVES*DATA_W], PREADY[NUM_SLAVES], PSLVERR[NUM_SLAVES]
// Modports: master (the APB master itself), slave (requester + APB slaves).
// -----------------------------------------------------------------------------
interface apb_master_mp_if #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [ADDR_W-1:0]            req_addr;
  logic [DATA_W-1:0]            req_wdata;
  logic [STRB_W-1:0]            req_strb;

  logic                         rsp_valid;
  logic [DATA_W-1:0]            rsp_rdata;
  logic                         rsp_err;
  logic                         rsp_timeout;

  logic [NUM_SLAVES-1:0]        PSEL;
  logic                         PENABLE;
  logic                         PWRITE;
  logic [ADDR_W-1:0]            PADDR;
  logic [DATA_W-1:0]            PWDATA;
  logic [STRB_W-1:0]            PSTRB;
  logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]        PREADY;
  logic [NUM_SLAVES-1:0]        PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

endinterface

// File: rtl/apb_rsp_mux.sv
// -----------------------------------------------------------------------------
// apb_rsp_mux
// Combinational selection of the addressed slave's response signals.
//   idx       in  SEL_W               slave index
//   prdata    in  NUM_SLAVES*DATA_W   concatenated read data, slave i at [i*DATA_W +: DATA_W]
//   pready    in  NUM_SLAVES          per-slave ready
//   pslverr   in  NUM_SLAVES          per-slave error
//   rdata_sel out DATA_W              read data of slave idx (0 if idx unmapped)
//   ready_sel out 1                   PREADY of slave idx
//   err_sel   out 1                   PSLVERR of slave idx
// -----------------------------------------------------------------------------
module apb_rsp_mux #(
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]             idx,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr,
  output logic [DATA_W-1:0]            rdata_sel,
  output logic                         ready_sel,
  output logic                         err_sel
);

  logic hit_s;

  // AND-OR select: unselected slaves contribute nothing, unmapped idx yields 0.
  always_comb begin
    rdata_sel = '0;
    ready_sel = 1'b0;
    err_sel   = 1'b0;
    hit_s     = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit_s     = (idx == SEL_W'(i));
      rdata_sel = rdata_sel | ({DATA_W{hit_s}} & prdata[i*DATA_W +: DATA_W]);
      ready_sel = ready_sel | (hit_s & pready[i]);
      err_sel   = err_sel   | (hit_s & pslverr[i]);
    end
  end

endmodule

// File: rtl/apb_master_mp.sv
// -----------------------------------------------------------------------------
// apb_master_mp
// Parametrised APB4 master with NUM_SLAVES decoded PSEL lines. Requests arrive
// on a valid/ready front-end, run as SETUP/ACCESS transfers, and complete with a
// one-cycle rsp_valid pulse carrying read data, error and timeout status.
// Back-to-back transfers go straight from ACCESS to the next SETUP.
//   PCLK    in  clock
//   PRESET  in  asynchronous active-high reset
//   bus     apb_master_mp_if.master : request/response front-end + APB4 bus
// All outputs are registered except req_ready.
// -----------------------------------------------------------------------------
module apb_master_mp
  import apb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_master_mp_if.master bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (clog2(NUM_SLAVES) < 32'sd1) ? 32'sd1 : clog2(NUM_SLAVES);
  localparam int WCNT_W = (clog2(TIMEOUT + 32'sd1) < 32'sd1) ? 32'sd1 : clog2(TIMEOUT + 32'sd1);
  // Counter value of the last ACCESS cycle allowed before abort.
  localparam logic [WCNT_W-1:0] TMO_LAST  = (TIMEOUT > 32'sd0) ? WCNT_W'(TIMEOUT - 32'sd1) : '0;
  // One extra bit so the comparison also works when NUM_SLAVES == 2**SEL_W.
  localparam logic [SEL_W:0]    SLAVE_LIM = (SEL_W + 1)'(NUM_SLAVES);

  apb_state_e            state_r, state_s;
  logic [WCNT_W-1:0]     wait_cnt_r, wait_cnt_s;
  logic [NUM_SLAVES-1:0] psel_r, psel_s;
  logic                  penable_r, penable_s;
  logic                  pwrite_r, pwrite_s;
  logic [ADDR_W-1:0]     paddr_r, paddr_s;
  logic [DATA_W-1:0]     pwdata_r, pwdata_s;
  logic [STRB_W-1:0]     pstrb_r, pstrb_s;
  logic                  rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0]     rsp_rdata_r, rsp_rdata_s;
  logic                  rsp_err_r, rsp_err_s;
  logic                  rsp_timeout_r, rsp_timeout_s;

  logic [SEL_W-1:0]      req_idx_s;
  logic [SEL_W-1:0]      cur_idx_s;
  logic                  req_mapped_s;
  logic [MAX_SLAVES-1:0] req_onehot_s;
  logic                  in_access_s;
  logic                  tmo_hit_s;
  logic                  done_s;
  logic                  req_ready_s;
  logic                  accept_s;
  logic                  start_s;
  logic [DATA_W-1:0]     sel_rdata_s;
  logic                  sel_ready_s;
  logic                  sel_err_s;

  // PADDR holds the latched request address for the whole transfer.
  assign cur_idx_s = paddr_r[ADDR_W-1 -: SEL_W];

  apb_rsp_mux #(
    .DATA_W     (DATA_W),
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_rsp_mux (
    .idx       (cur_idx_s),
    .prdata    (bus.PRDATA),
    .pready    (bus.PREADY),
    .pslverr   (bus.PSLVERR),
    .rdata_sel (sel_rdata_s),
    .ready_sel (sel_ready_s),
    .err_sel   (sel_err_s)
  );

  // Handshake terms: completion, timeout and request acceptance.
  always_comb begin
    req_idx_s    = bus.req_addr[ADDR_W-1 -: SEL_W];
    req_mapped_s = ({1'b0, req_idx_s} < SLAVE_LIM);
    req_onehot_s = onehot(4'(req_idx_s));
    in_access_s  = (state_r == ST_ACCESS);
    // Defined with !PREADY so a ready slave always beats the timeout.
    tmo_hit_s    = (TIMEOUT != 32'sd0) && in_access_s && (wait_cnt_r == TMO_LAST) && !sel_ready_s;
    done_s       = in_access_s && (sel_ready_s || tmo_hit_s);
    // Held low during reset so no output is active while PRESET is high.
    req_ready_s  = !PRESET && ((state_r == ST_IDLE) || done_s);
    accept_s     = bus.req_valid && req_ready_s;
  end

  // Next-state and next-output logic of the transfer FSM.
  always_comb begin
    state_s       = state_r;
    wait_cnt_s    = wait_cnt_r;
    psel_s        = '0;
    penable_s     = 1'b0;
    pwrite_s      = pwrite_r;
    paddr_s       = paddr_r;
    pwdata_s      = pwdata_r;
    pstrb_s       = pstrb_r;
    rsp_valid_s   = 1'b0;
    rsp_rdata_s   = '0;
    rsp_err_s     = 1'b0;
    rsp_timeout_s = 1'b0;
    start_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        start_s = accept_s;
      end
      ST_SETUP: begin
        state_s    = ST_ACCESS;
        psel_s     = psel_r;
        penable_s  = 1'b1;
        wait_cnt_s = '0;
      end
      ST_ACCESS: begin
        if (done_s) begin
          state_s       = ST_IDLE;
          rsp_valid_s   = 1'b1;
          rsp_rdata_s   = (!pwrite_r && sel_ready_s && !sel_err_s) ? sel_rdata_s : '0;
          rsp_err_s     = sel_ready_s ? sel_err_s : 1'b1;
          rsp_timeout_s = tmo_hit_s;
          start_s       = accept_s;
        end else begin
          // Not done implies the selected PREADY is low: one more wait state.
          psel_s     = psel_r;
          penable_s  = 1'b1;
          wait_cnt_s = wait_cnt_r + WCNT_W'(1);
        end
      end
      ST_DECERR: begin
        state_s     = ST_IDLE;
        rsp_valid_s = 1'b1;
        rsp_err_s   = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // A newly accepted request overrides the IDLE return chosen above.
    if (start_s) begin
      if (req_mapped_s) begin
        state_s  = ST_SETUP;
        psel_s   = req_onehot_s[NUM_SLAVES-1:0];
        paddr_s  = bus.req_addr;
        pwrite_s = bus.req_write;
        pwdata_s = bus.req_write ? bus.req_wdata : '0;
        pstrb_s  = bus.req_write ? bus.req_strb : '0;
      end else begin
        state_s = ST_DECERR;
      end
    end else begin
      state_s = state_s;
    end
  end

  // State, counter and output registers; reset clears the bus immediately.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= '0;
      psel_r        <= '0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= '0;
      pwdata_r      <= '0;
      pstrb_r       <= '0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= '0;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      wait_cnt_r    <= wait_cnt_s;
      psel_r        <= psel_s;
      penable_r     <= penable_s;
      pwrite_r      <= pwrite_s;
      paddr_r       <= paddr_s;
      pwdata_r      <= pwdata_s;
      pstrb_r       <= pstrb_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_err_r     <= rsp_err_s;
      rsp_timeout_r <= rsp_timeout_s;
    end
  end

  assign bus.req_ready   = req_ready_s;
  assign bus.PSEL        = psel_r;
  assign bus.PENABLE     = penable_r;
  assign bus.PWRITE      = pwrite_r;
  assign bus.PADDR       = paddr_r;
  assign bus.PWDATA      = pwdata_r;
  assign bus.PSTRB       = pstrb_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_err     = rsp_err_r;
  assign bus.rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master_mp.sv
// -----------------------------------------------------------------------------
// tb_apb_master_mp
// Directed self-checking bench for apb_master_mp. u_dut4 has 4 slaves and
// TIMEOUT=16; u_dut3 has 3 slaves so address 0xC0 decodes to an unmapped slot.
// -----------------------------------------------------------------------------
module tb_apb_master_mp;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  int   n_asserts = 0;
  int   n_fails = 0;

  always #5 PCLK = ~PCLK;

  apb_master_mp_if #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(4)) b4 ();
  apb_master_mp_if #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(3)) b3 ();

  apb_master_mp #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(4), .TIMEOUT(16)) u_dut4 (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (b4)
  );

  apb_master_mp #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(3), .TIMEOUT(16)) u_dut3 (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (b3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    b4.req_valid = 1'b0; b4.req_write = 1'b0; b4.req_addr = 8'h00;
    b4.req_wdata = 32'h0; b4.req_strb = 4'h0;
    b4.PRDATA = 128'h0; b4.PREADY = 4'h0; b4.PSLVERR = 4'h0;
    b3.req_valid = 1'b0; b3.req_write = 1'b0; b3.req_addr = 8'h00;
    b3.req_wdata = 32'h0; b3.req_strb = 4'h0;
    b3.PRDATA = 96'h0; b3.PREADY = 3'h0; b3.PSLVERR = 3'h0;

    // Reset state
    tick(); tick();
    chk("rst_psel",      64'(b4.PSEL),      64'h0);
    chk("rst_penable",   64'(b4.PENABLE),   64'h0);
    chk("rst_rsp_valid", 64'(b4.rsp_valid), 64'h0);
    chk("rst_req_ready", 64'(b4.req_ready), 64'h0);
    chk("rst_paddr",     64'(b4.PADDR),     64'h0);
    chk("rst_psel3",     64'(b3.PSEL),      64'h0);
    PRESET = 1'b0;
    #1;
    chk("idle_req_ready", 64'(b4.req_ready), 64'h1);

    // Zero-wait write to slave 1
    b4.req_valid = 1'b1; b4.req_write = 1'b1; b4.req_addr = 8'h44;
    b4.req_wdata = 32'hDEADBEEF; b4.req_strb = 4'hF; b4.PREADY = 4'b0010;
    tick();
    b4.req_valid = 1'b0; b4.req_wdata = 32'h0;
    #1;
    chk("t1_setup_psel",    64'(b4.PSEL),      64'h2);
    chk("t1_setup_penable", 64'(b4.PENABLE),   64'h0);
    chk("t1_setup_pstrb",   64'(b4.PSTRB),     64'hF);
    chk("t1_setup_pwdata",  64'(b4.PWDATA),    64'hDEADBEEF);
    chk("t1_setup_paddr",   64'(b4.PADDR),     64'h44);
    chk("t1_setup_pwrite",  64'(b4.PWRITE),    64'h1);
    chk("t1_setup_ready",   64'(b4.req_ready), 64'h0);
    tick();
    chk("t1_acc_psel",      64'(b4.PSEL),      64'h2);
    chk("t1_acc_penable",   64'(b4.PENABLE),   64'h1);
    chk("t1_acc_pwdata",    64'(b4.PWDATA),    64'hDEADBEEF);
    chk("t1_acc_ready",     64'(b4.req_ready), 64'h1);
    chk("t1_acc_rsp_valid", 64'(b4.rsp_valid), 64'h0);
    tick();
    chk("t1_rsp_valid",   64'(b4.rsp_valid),   64'h1);
    chk("t1_rsp_err",     64'(b4.rsp_err),     64'h0);
    chk("t1_rsp_timeout", 64'(b4.rsp_timeout), 64'h0);
    chk("t1_rsp_rdata",   64'(b4.rsp_rdata),   64'h0);
    chk("t1_idle_psel",   64'(b4.PSEL),        64'h0);
    chk("t1_idle_penable", 64'(b4.PENABLE),    64'h0);
    chk("t1_idle_paddr",  64'(b4.PADDR),       64'h44);
    tick();
    chk("t1_rsp_pulse", 64'(b4.rsp_valid), 64'h0);

    // Read from slave 2 with 3 wait states; other slaves flag errors
    b4.PREADY = 4'b0000; b4.PSLVERR = 4'b1011;
    b4.PRDATA = {32'hFFFF0000, 32'h12345678, 32'hAAAAAAAA, 32'h55555555};
    b4.req_valid = 1'b1; b4.req_write = 1'b0; b4.req_addr = 8'h80;
    b4.req_wdata = 32'hA5A5A5A5; b4.req_strb = 4'hF;
    tick();
    b4.req_valid = 1'b0;
    #1;
    chk("t2_setup_psel",   64'(b4.PSEL),    64'h4);
    chk("t2_setup_penable", 64'(b4.PENABLE), 64'h0);
    chk("t2_setup_pstrb",  64'(b4.PSTRB),   64'h0);
    chk("t2_setup_pwdata", 64'(b4.PWDATA),  64'h0);
    chk("t2_setup_pwrite", 64'(b4.PWRITE),  64'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) b4.PREADY = 4'b0100;
      #1;
      chk("t2_acc_penable",   64'(b4.PENABLE),   64'h1);
      chk("t2_acc_psel",      64'(b4.PSEL),      64'h4);
      chk("t2_acc_rsp_valid", 64'(b4.rsp_valid), 64'h0);
      chk("t2_acc_ready",     64'(b4.req_ready), 64'(i == 4));
    end
    tick();
    chk("t2_rsp_valid",   64'(b4.rsp_valid),   64'h1);
    chk("t2_rsp_rdata",   64'(b4.rsp_rdata),   64'h12345678);
    chk("t2_rsp_err",     64'(b4.rsp_err),     64'h0);
    chk("t2_rsp_timeout", 64'(b4.rsp_timeout), 64'h0);
    chk("t2_idle_penable", 64'(b4.PENABLE),    64'h0);
    chk("t2_idle_psel",   64'(b4.PSEL),        64'h0);
    b4.PREADY = 4'b0000; b4.PSLVERR = 4'b0000;

    // Back-to-back: write slave 0 then read slave 3, zero wait
    b4.PREADY = 4'hF;
    b4.PRDATA = {32'hCAFEF00D, 32'h0, 32'h0, 32'h0};
    b4.req_valid = 1'b1; b4.req_write = 1'b1; b4.req_addr = 8'h10;
    b4.req_wdata = 32'h11223344; b4.req_strb = 4'h3;
    tick();
    chk("t3_s1_psel",    64'(b4.PSEL),    64'h1);
    chk("t3_s1_penable", 64'(b4.PENABLE), 64'h0);
    chk("t3_s1_pstrb",   64'(b4.PSTRB),   64'h3);
    b4.req_write = 1'b0; b4.req_addr = 8'hC4; b4.req_wdata = 32'h0; b4.req_strb = 4'hF;
    #1;
    chk("t3_s1_ready", 64'(b4.req_ready), 64'h0);
    tick();
    chk("t3_a1_psel",    64'(b4.PSEL),      64'h1);
    chk("t3_a1_penable", 64'(b4.PENABLE),   64'h1);
    chk("t3_a1_pwdata",  64'(b4.PWDATA),    64'h11223344);
    chk("t3_a1_pwrite",  64'(b4.PWRITE),    64'h1);
    chk("t3_a1_ready",   64'(b4.req_ready), 64'h1);
    tick();
    b4.req_valid = 1'b0;
    #1;
    chk("t3_s2_psel",      64'(b4.PSEL),      64'h8);
    chk("t3_s2_penable",   64'(b4.PENABLE),   64'h0);
    chk("t3_s2_pwrite",    64'(b4.PWRITE),    64'h0);
    chk("t3_s2_paddr",     64'(b4.PADDR),     64'hC4);
    chk("t3_s2_pstrb",     64'(b4.PSTRB),     64'h0);
    chk("t3_s2_rsp_valid", 64'(b4.rsp_valid), 64'h1);
    chk("t3_s2_rsp_err",   64'(b4.rsp_err),   64'h0);
    chk("t3_s2_rsp_rdata", 64'(b4.rsp_rdata), 64'h0);
    tick();
    chk("t3_a2_psel",      64'(b4.PSEL),      64'h8);
    chk("t3_a2_penable",   64'(b4.PENABLE),   64'h1);
    chk("t3_a2_rsp_valid", 64'(b4.rsp_valid), 64'h0);
    tick();
    chk("t3_end_psel",  64'(b4.PSEL),      64'h0);
    chk("t3_rsp_valid", 64'(b4.rsp_valid), 64'h1);
    chk("t3_rsp_rdata", 64'(b4.rsp_rdata), 64'hCAFEF00D);
    chk("t3_rsp_err",   64'(b4.rsp_err),   64'h0);

    // Timeout: slave 1 never ready
    b4.PREADY = 4'h0;
    b4.PRDATA = {32'h77777777, 32'h77777777, 32'h77777777, 32'h77777777};
    b4.req_valid = 1'b1; b4.req_write = 1'b0; b4.req_addr = 8'h40;
    tick();
    b4.req_valid = 1'b0;
    #1;
    chk("t4_setup_psel", 64'(b4.PSEL), 64'h2);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("t4_acc_penable",   64'(b4.PENABLE),   64'h1);
      chk("t4_acc_rsp_valid", 64'(b4.rsp_valid), 64'h0);
      chk("t4_acc_ready",     64'(b4.req_ready), 64'(i == 16));
    end
    tick();
    chk("t4_rsp_valid",   64'(b4.rsp_valid),   64'h1);
    chk("t4_rsp_err",     64'(b4.rsp_err),     64'h1);
    chk("t4_rsp_timeout", 64'(b4.rsp_timeout), 64'h1);
    chk("t4_rsp_rdata",   64'(b4.rsp_rdata),   64'h0);
    chk("t4_idle_psel",   64'(b4.PSEL),        64'h0);
    chk("t4_idle_penable", 64'(b4.PENABLE),    64'h0);
    tick();
    chk("t4_rsp_pulse", 64'(b4.rsp_valid), 64'h0);
    chk("t4_idle_ready", 64'(b4.req_ready), 64'h1);

    // Decode error on the 3-slave master
    b3.PREADY = 3'b111;
    b3.req_valid = 1'b1; b3.req_write = 1'b0; b3.req_addr = 8'hC0;
    tick();
    b3.req_valid = 1'b0;
    #1;
    chk("t5_dec_psel",      64'(b3.PSEL),      64'h0);
    chk("t5_dec_penable",   64'(b3.PENABLE),   64'h0);
    chk("t5_dec_rsp_valid", 64'(b3.rsp_valid), 64'h0);
    chk("t5_dec_ready",     64'(b3.req_ready), 64'h0);
    tick();
    chk("t5_rsp_valid",   64'(b3.rsp_valid),   64'h1);
    chk("t5_rsp_err",     64'(b3.rsp_err),     64'h1);
    chk("t5_rsp_timeout", 64'(b3.rsp_timeout), 64'h0);
    chk("t5_rsp_rdata",   64'(b3.rsp_rdata),   64'h0);
    chk("t5_rsp_psel",    64'(b3.PSEL),        64'h0);
    chk("t5_rsp_ready",   64'(b3.req_ready),   64'h1);
    tick();
    chk("t5_rsp_pulse", 64'(b3.rsp_valid), 64'h0);

    // PSLVERR from slave 0 on a read
    b4.PREADY = 4'b0001; b4.PSLVERR = 4'b0001;
    b4.PRDATA = {32'h0, 32'h0, 32'h0, 32'h55AA55AA};
    b4.req_valid = 1'b1; b4.req_write = 1'b0; b4.req_addr = 8'h08;
    tick();
    b4.req_valid = 1'b0;
    #1;
    chk("t6_setup_psel", 64'(b4.PSEL), 64'h1);
    tick();
    chk("t6_acc_penable", 64'(b4.PENABLE), 64'h1);
    tick();
    chk("t6_rsp_valid",   64'(b4.rsp_valid),   64'h1);
    chk("t6_rsp_err",     64'(b4.rsp_err),     64'h1);
    chk("t6_rsp_timeout", 64'(b4.rsp_timeout), 64'h0);
    chk("t6_rsp_rdata",   64'(b4.rsp_rdata),   64'h0);

    // Reset asserted mid-ACCESS of the next transfer
    b4.PREADY = 4'h0; b4.PSLVERR = 4'h0;
    b4.req_valid = 1'b1; b4.req_write = 1'b1; b4.req_addr = 8'h84;
    b4.req_wdata = 32'h1; b4.req_strb = 4'hF;
    tick();
    b4.req_valid = 1'b0;
    #1;
    chk("t7_setup_psel", 64'(b4.PSEL), 64'h4);
    tick();
    tick();
    chk("t7_acc_psel",    64'(b4.PSEL),    64'h4);
    chk("t7_acc_penable", 64'(b4.PENABLE), 64'h1);
    #2;
    PRESET = 1'b1;
    #1;
    chk("t7_rst_psel",    64'(b4.PSEL),      64'h0);
    chk("t7_rst_penable", 64'(b4.PENABLE),   64'h0);
    chk("t7_rst_ready",   64'(b4.req_ready), 64'h0);
    b4.PREADY = 4'b0100;
    tick();
    chk("t7_rst_rsp_valid_a", 64'(b4.rsp_valid), 64'h0);
    tick();
    chk("t7_rst_rsp_valid_b", 64'(b4.rsp_valid), 64'h0);
    chk("t7_rst_psel_b",      64'(b4.PSEL),      64'h0);
    PRESET = 1'b0;
    b4.PREADY = 4'h0;
    tick();
    chk("t7_post_rsp_valid_a", 64'(b4.rsp_valid), 64'h0);
    chk("t7_post_psel",        64'(b4.PSEL),      64'h0);
    chk("t7_post_penable",     64'(b4.PENABLE),   64'h0);
    tick();
    chk("t7_post_rsp_valid_b", 64'(b4.rsp_valid), 64'h0);
    chk("t7_post_ready",       64'(b4.req_ready), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
